// File: rtl/seg_event_counter.sv
// Free-running pattern counter with masked LED output; rising edges of the LED MSB
// are counted in 4-digit BCD and shown on a multiplexed active-low 7-segment display.
module seg_event_counter #(
  parameter int CNT_W    = 8,
  parameter int TICK_DIV = 4194304,
  parameter int SCAN_DIV = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] Sw,
  input  logic             hold,
  input  logic             clr,
  output logic [CNT_W-1:0] Led,
  output logic [7:0]       seg,
  output logic [3:0]       an
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0]  pre;
  logic [SCAN_W-1:0] scan;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        idx;
  logic              msb_q;
  logic              clr_q;
  logic [3:0][3:0]   bcd;
  logic [3:0][3:0]   bcd_inc;
  logic              tick;
  logic              scan_wrap;
  logic              evt;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign tick      = (pre == PRE_W'(TICK_DIV - 1));
  assign scan_wrap = (scan == SCAN_W'(SCAN_DIV - 1));
  // After a clear, Led still carries the pre-clear pattern for one cycle while the
  // history is zero; clr_q masks that cycle so it cannot be taken as a rising edge.
  assign evt       = Led[CNT_W-1] & ~msb_q & ~clr_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    logic carry;
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[i] == 4'd9) begin
          bcd_inc[i] = 4'd0;
        end else begin
          bcd_inc[i] = bcd[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      cnt   <= '0;
      Led   <= '0;
      msb_q <= 1'b0;
      clr_q <= 1'b0;
      // NOTE: the BCD digits are a packed vector of flops, so they take the async reset.
      bcd   <= '0;
    end else begin
      Led <= cnt & Sw;
      if (clr) begin
        pre   <= '0;
        cnt   <= '0;
        msb_q <= 1'b0;
        clr_q <= 1'b1;
        bcd   <= '0;
      end else begin
        clr_q <= 1'b0;
        msb_q <= Led[CNT_W-1];
        pre   <= tick ? '0 : pre + PRE_W'(1);
        if (tick && !hold) cnt <= cnt + CNT_W'(1);
        if (evt) bcd <= bcd_inc;
      end
    end
  end

  // Display scan runs independently of clr and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
      idx  <= 2'd0;
      an   <= 4'hF;
      seg  <= 8'hFF;
    end else begin
      scan <= scan_wrap ? '0 : scan + SCAN_W'(1);
      if (scan_wrap) idx <= idx + 2'd1;
      an  <= ~(4'b0001 << idx);
      seg <= {1'b1, glyph(bcd[idx])};
    end
  end

endmodule

// File: tb/tb_seg_event_counter.sv
// Directed bench: one DUT at CNT_W=8/TICK_DIV=4/SCAN_DIV=3, a second at CNT_W=2/TICK_DIV=2
// run long enough to wrap the BCD counter past 9999.
module tb_seg_event_counter;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [7:0] sw1, led1, seg1;
  logic       hold1, clr1;
  logic [3:0] an1;
  logic [1:0] sw2, led2;
  logic       hold2, clr2;
  logic [7:0] seg2;
  logic [3:0] an2;

  int n_checks = 0;
  int n_err    = 0;
  int e1       = 0;

  always #5 clk = ~clk;

  seg_event_counter #(.CNT_W(8), .TICK_DIV(4), .SCAN_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .Sw(sw1), .hold(hold1), .clr(clr1),
    .Led(led1), .seg(seg1), .an(an1)
  );

  seg_event_counter #(.CNT_W(2), .TICK_DIV(2), .SCAN_DIV(3)) dut2 (
    .clk(clk), .rst_n(rst2_n), .Sw(sw2), .hold(hold2), .clr(clr2),
    .Led(led2), .seg(seg2), .an(an2)
  );

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: glyph = 8'hC0;  1: glyph = 8'hF9;  2: glyph = 8'hA4;  3: glyph = 8'hB0;
      4: glyph = 8'h99;  5: glyph = 8'h92;  6: glyph = 8'h82;  7: glyph = 8'hF8;
      8: glyph = 8'h80;  9: glyph = 8'h90;  default: glyph = 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] an_code(input int i);
    logic [3:0] r;
    r    = 4'b1111;
    r[i] = 1'b0;
    return r;
  endfunction

  function automatic int digit(input int v, input int i);
    int p;
    p = 1;
    repeat (i) p = p * 10;
    return (v / p) % 10;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go1(input int target);
    while (e1 < target) begin
      @(negedge clk);
      e1++;
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    sw1 = 8'hFF; hold1 = 1'b0; clr1 = 1'b0;
    sw2 = 2'b11; hold2 = 1'b0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led",  led1, 8'h00);
    check("rst_an",   an1,  4'hF);
    check("rst_seg",  seg1, 8'hFF);
    check("rst2_seg", seg2, 8'hFF);

    fork
      begin : main_dut
        rst_n = 1'b1;
        e1 = 0;
        go1(1);    check("first_an", an1, 4'b1110); check("first_seg", seg1, 8'hC0);
                   check("first_led", led1, 8'h00);
        go1(3);    check("scan_an3", an1, 4'b1110);
        go1(4);    check("scan_an4", an1, 4'b1101); check("led_pre_tick", led1, 8'h00);
        go1(5);    check("led_first_tick", led1, 8'h01);
        go1(7);    check("scan_an7", an1, 4'b1011);
        go1(10);   check("scan_an10", an1, 4'b0111);
        go1(13);   check("scan_an13", an1, 4'b1110);
        go1(512);  check("led_7f", led1, 8'h7F);
        go1(513);  check("led_80", led1, 8'h80);
        go1(515);  check("dig3_zero", seg1, 8'hC0); check("dig3_an", an1, 4'b0111);
        go1(517);  check("bcd1_dig0", seg1, 8'hF9); check("bcd1_an", an1, 4'b1110);
        go1(1024); check("led_ff", led1, 8'hFF);
        go1(1025); check("led_wrap", led1, 8'h00);
        go1(1033); check("bcd_stays1", seg1, 8'hF9);
        go1(1537); check("led_80_again", led1, 8'h80); check("bcd_still1", seg1, 8'hF9);
        go1(1549); check("bcd2_dig0", seg1, 8'hA4);

        hold1 = 1'b1;
        go1(1551); check("hold_a", led1, 8'h83);
        go1(1560); check("hold_b", led1, 8'h83);
        go1(1569); check("hold_c", led1, 8'h83);
        hold1 = 1'b0;
        go1(1572); check("resume_wait", led1, 8'h83);
        go1(1573); check("resume_inc", led1, 8'h84);
        go1(1576); check("resume_same", led1, 8'h84);
        go1(1577); check("resume_space4", led1, 8'h85);

        go1(1579); clr1 = 1'b1;
        go1(1580); clr1 = 1'b0; check("clr_led_lag", led1, 8'h85);
        go1(1581); check("clr_led0", led1, 8'h00); check("clr_scan_an", an1, 4'b1011);
        for (int j = 2; j <= 13; j++) begin
          go1(1580 + j);
          check("clr_bcd0", seg1, 8'hC0);
        end
        check("clr_led_count", led1, 8'h03);

        sw1 = 8'h7F;
        while (e1 < 6476) begin
          go1(e1 + 1);
          check("mask_msb", {7'd0, led1[7]}, 8'h00);
          check("mask_bcd", seg1, 8'hC0);
        end
        check("mask_led", led1, 8'h47);
        sw1 = 8'hFF;
        go1(6477); check("unmask_led", led1, 8'hC8);
        go1(6481); check("unmask_evt", seg1, 8'hF9); check("unmask_an", an1, 4'b1110);
        go1(6484); check("unmask_dig1", seg1, 8'hC0); check("unmask_an1", an1, 4'b1101);
        go1(6721); check("unmask_once", seg1, 8'hF9); check("unmask_an2", an1, 4'b1110);

        #2 rst_n = 1'b0;
        #1 check("midrst_led", led1, 8'h00); check("midrst_an", an1, 4'hF);
           check("midrst_seg", seg1, 8'hFF);
        @(negedge clk);
        check("midrst_hold_an", an1, 4'hF);
        rst_n = 1'b1;
        e1 = 0;
        go1(1); check("rel_an", an1, 4'b1110); check("rel_seg", seg1, 8'hC0);
                check("rel_led", led1, 8'h00);
        go1(4); check("rel_led4", led1, 8'h00); check("rel_an4", an1, 4'b1101);
        go1(5); check("rel_tick", led1, 8'h01);
      end

      begin : wrap_dut
        rst2_n = 1'b1;
        for (int k = 1; k <= 80021; k++) begin
          int m, ix, v;
          @(negedge clk);
          m  = k - 1;
          ix = (m / 3) % 4;
          v  = ((m + 2) / 8) % 10000;
          check("w_an",  an2,  an_code(ix));
          check("w_seg", seg2, glyph(digit(v, ix)));
          check("w_led", led2, ((k - 1) / 2) % 4);
        end
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        check("wclr_led_lag", led2, 2'd2);
        @(negedge clk);
        check("wclr_led0", led2, 2'd0);
        check("wclr_an", an2, 4'b1011);
        check("wclr_seg", seg2, 8'hC0);
        repeat (5) begin
          @(negedge clk);
          check("wclr_bcd0", seg2, 8'hC0);
        end
        @(negedge clk);
        check("wclr_first_evt", seg2, 8'hF9);
        check("wclr_an0", an2, 4'b1110);
      end
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
